// File: rtl/crossbar_allocator.sv
// Per-output packet allocator for a NUM_IN x NUM_OUT crossbar: round-robin arbitration
// in IDLE, then a wormhole-style lock held until the owner's tail flit crosses.
module crossbar_allocator #(
   parameter int NUM_IN  = 4,
   parameter int NUM_OUT = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [NUM_IN-1:0]                          req_valid,
   input  logic [NUM_IN-1:0][$clog2(NUM_OUT)-1:0]     req_out,
   input  logic [NUM_IN-1:0]                          req_last,
   input  logic [NUM_OUT-1:0]                         out_ready,
   output logic [NUM_IN-1:0]                          grant,
   output logic [NUM_OUT-1:0][$clog2(NUM_IN)-1:0]     sel,
   output logic [NUM_OUT-1:0]                         enable
);

   localparam int IW = $clog2(NUM_IN);
   localparam int OW = $clog2(NUM_OUT);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   logic [NUM_OUT-1:0]          w_locked;
   logic [NUM_OUT-1:0][IW-1:0]  w_owner;
   logic [NUM_IN-1:0]           w_busy;

   // Inputs already holding a locked output may not win a second one.
   always_comb begin
      w_busy = '0;
      for (int o = 0; o < NUM_OUT; o++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (w_locked[o] && (w_owner[o] == IW'(i))) begin
               w_busy[i] = 1'b1;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
         state_t              r_state;
         state_t              w_state_next;
         logic [IW-1:0]       r_owner;
         logic [IW-1:0]       w_owner_next;
         logic [IW-1:0]       r_rr_ptr;
         logic [IW-1:0]       w_rr_ptr_next;
         logic [NUM_IN-1:0]   w_cand;
         logic                w_hit_hi;
         logic                w_hit_lo;
         logic [IW-1:0]       w_win_hi;
         logic [IW-1:0]       w_win_lo;
         logic                w_found;
         logic [IW-1:0]       w_winner;
         logic                w_enable;
         logic [IW-1:0]       w_sel;

         // Round-robin: first candidate above rr_ptr wins, else first at or below it.
         always_comb begin
            w_cand   = '0;
            w_hit_hi = 1'b0;
            w_hit_lo = 1'b0;
            w_win_hi = '0;
            w_win_lo = '0;
            for (int i = 0; i < NUM_IN; i++) begin
               w_cand[i] = req_valid[i] && (req_out[i] == OW'(gi)) && !w_busy[i];
               if (w_cand[i] && (IW'(i) > r_rr_ptr) && !w_hit_hi) begin
                  w_hit_hi = 1'b1;
                  w_win_hi = IW'(i);
               end
               if (w_cand[i] && (IW'(i) <= r_rr_ptr) && !w_hit_lo) begin
                  w_hit_lo = 1'b1;
                  w_win_lo = IW'(i);
               end
            end
            w_found  = w_hit_hi || w_hit_lo;
            w_winner = w_hit_hi ? w_win_hi : w_win_lo;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_state  <= S_IDLE;
               r_owner  <= '0;
               r_rr_ptr <= IW'(NUM_IN - 1);
            end else begin
               r_state  <= w_state_next;
               r_owner  <= w_owner_next;
               r_rr_ptr <= w_rr_ptr_next;
            end
         end

         always_comb begin
            w_state_next  = r_state;
            w_owner_next  = r_owner;
            w_rr_ptr_next = r_rr_ptr;
            case (r_state)
               S_IDLE: begin
                  if (w_found) begin
                     w_owner_next = w_winner;
                     w_state_next = S_LOCKED;
                  end
               end
               S_LOCKED: begin
                  // Released owner drops to lowest priority for the next arbitration.
                  if (w_enable && req_last[r_owner]) begin
                     w_state_next  = S_IDLE;
                     w_rr_ptr_next = r_owner;
                  end
               end
               default: w_state_next = S_IDLE;
            endcase
         end

         always_comb begin
            w_sel    = r_owner;
            w_enable = (r_state == S_LOCKED) && req_valid[r_owner] && out_ready[gi];
         end

         assign enable[gi]   = w_enable;
         assign sel[gi]      = w_sel;
         assign w_locked[gi] = (r_state == S_LOCKED);
         assign w_owner[gi]  = r_owner;
      end
   endgenerate

   // Enable already implies LOCKED, so it is sufficient to qualify by owner.
   always_comb begin
      grant = '0;
      for (int o = 0; o < NUM_OUT; o++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (enable[o] && (w_owner[o] == IW'(i))) begin
               grant[i] = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_crossbar_allocator.sv
// Scoreboard bench for crossbar_allocator: hand-derived expectations queued per cycle,
// popped and compared against the DUT at the falling edge.
module tb_crossbar_allocator;

   logic             clk;
   logic             rst;
   logic [3:0]       req_valid;
   logic [3:0][1:0]  req_out;
   logic [3:0]       req_last;
   logic [3:0]       out_ready;
   logic [3:0]       grant;
   logic [3:0][1:0]  sel;
   logic [3:0]       enable;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       tag;
      logic [3:0]  eg;
      logic [3:0]  ee;
      logic [7:0]  es;
      logic [7:0]  em;
   } exp_t;

   exp_t sb[$];

   crossbar_allocator #(.NUM_IN(4), .NUM_OUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_out   (req_out),
      .req_last  (req_last),
      .out_ready (out_ready),
      .grant     (grant),
      .sel       (sel),
      .enable    (enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] pk(input int a, input int b, input int c, input int d);
      return {d[1:0], c[1:0], b[1:0], a[1:0]};
   endfunction

   task automatic compare_front();
      exp_t e;
      if (sb.size() == 0) begin
         check_val("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_val({e.tag, " grant"},  32'(grant),  32'(e.eg));
         check_val({e.tag, " enable"}, 32'(enable), 32'(e.ee));
         if (e.em != 8'h00) begin
            check_val({e.tag, " sel"}, 32'(sel & e.em), 32'(e.es & e.em));
         end
         $display("cycle %s: grant=%b enable=%b sel=%h", e.tag, grant, enable, sel);
      end
   endtask

   task automatic step(input string tag, input logic [3:0] rv, input logic [7:0] ro,
                       input logic [3:0] rl, input logic [3:0] rdy,
                       input logic [3:0] eg, input logic [3:0] ee,
                       input logic [7:0] es, input logic [7:0] em);
      exp_t e;
      req_valid = rv;
      req_out   = ro;
      req_last  = rl;
      out_ready = rdy;
      e.tag = tag; e.eg = eg; e.ee = ee; e.es = es; e.em = em;
      sb.push_back(e);
      @(negedge clk);
      compare_front();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] r;
      exp_t       e;
      int         w;
      rst       = 1'b1;
      req_valid = '0;
      req_out   = '0;
      req_last  = '0;
      out_ready = '0;
      @(posedge clk);
      #1;
      // Outputs held low in reset regardless of requests.
      step("rst", 4'b1111, pk(1,1,1,1), 4'b1111, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'hFF);
      rst = 1'b0;

      // 3-flit packet input0 -> out2, then a single-flit packet after the bubble.
      r = pk(2,0,0,0);
      step("t1c0", 4'b0001, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t1c1", 4'b0001, r, 4'b0000, 4'b1111, 4'b0001, 4'b0100, 8'h00, 8'h30);
      step("t1c2", 4'b0001, r, 4'b0000, 4'b1111, 4'b0001, 4'b0100, 8'h00, 8'h30);
      step("t1c3", 4'b0001, r, 4'b0001, 4'b1111, 4'b0001, 4'b0100, 8'h00, 8'h30);
      step("t1c4", 4'b0001, r, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t1c5", 4'b0001, r, 4'b0001, 4'b1111, 4'b0001, 4'b0100, 8'h00, 8'h30);
      step("t1c6", 4'b0000, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);

      // All inputs contend for out1 with single-flit packets: order 0,1,2,3,0.
      r = pk(1,1,1,1);
      for (int k = 0; k < 10; k++) begin
         w = (k / 2) % 4;
         if (k % 2 == 0)
            step($sformatf("t2c%0d", k), 4'b1111, r, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
         else
            step($sformatf("t2c%0d", k), 4'b1111, r, 4'b1111, 4'b1111, 4'(1 << w), 4'b0010, pk(0,w,0,0), 8'h0C);
      end
      step("t2c10", 4'b0000, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);

      // Backpressure on out3 while input2 owns it; input0 waits.
      r = pk(3,0,3,0);
      step("t3c0", 4'b0100, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t3c1", 4'b0100, r, 4'b0000, 4'b1111, 4'b0100, 4'b1000, pk(0,0,0,2), 8'hC0);
      for (int k = 2; k < 6; k++)
         step($sformatf("t3c%0d", k), 4'b0101, r, 4'b0000, 4'b0111, 4'b0000, 4'b0000, pk(0,0,0,2), 8'hC0);
      step("t3c6", 4'b0101, r, 4'b0000, 4'b1111, 4'b0100, 4'b1000, pk(0,0,0,2), 8'hC0);
      step("t3c7", 4'b0101, r, 4'b0100, 4'b1111, 4'b0100, 4'b1000, pk(0,0,0,2), 8'hC0);
      step("t3c8", 4'b0001, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t3c9", 4'b0001, r, 4'b0001, 4'b1111, 4'b0001, 4'b1000, pk(0,0,0,0), 8'hC0);
      step("t3c10", 4'b0000, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);

      // Bubbles from input1 on out0 while input3 waits for the lock to release.
      r = pk(0,0,0,0);
      step("t4c0", 4'b0010, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t4c1", 4'b1010, r, 4'b0000, 4'b1111, 4'b0010, 4'b0001, pk(1,0,0,0), 8'h03);
      step("t4c2", 4'b1000, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, pk(1,0,0,0), 8'h03);
      step("t4c3", 4'b1000, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, pk(1,0,0,0), 8'h03);
      step("t4c4", 4'b1010, r, 4'b0010, 4'b1111, 4'b0010, 4'b0001, pk(1,0,0,0), 8'h03);
      step("t4c5", 4'b1000, r, 4'b1000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t4c6", 4'b1000, r, 4'b1000, 4'b1111, 4'b1000, 4'b0001, pk(3,0,0,0), 8'h03);
      step("t4c7", 4'b0000, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);

      // Four disjoint allocations in the same cycle.
      r = pk(0,1,2,3);
      step("t5c0", 4'b1111, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t5c1", 4'b1111, r, 4'b1111, 4'b1111, 4'b1111, 4'b1111, pk(0,1,2,3), 8'hFF);
      step("t5c2", 4'b0000, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);

      // Asynchronous reset in the middle of a packet on out2.
      r = pk(2,0,0,0);
      step("t6c0", 4'b0001, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t6c1", 4'b0001, r, 4'b0000, 4'b1111, 4'b0001, 4'b0100, pk(0,0,0,0), 8'h30);
      rst = 1'b1;
      e.tag = "t6rst"; e.eg = 4'b0000; e.ee = 4'b0000; e.es = 8'h00; e.em = 8'hFF;
      sb.push_back(e);
      #1;
      compare_front();
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 4'b0000;
      @(posedge clk);
      #1;

      // Contest on out0 after reset: input0 must win first.
      r = pk(0,0,0,0);
      step("t6c2", 4'b0011, r, 4'b0011, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t6c3", 4'b0011, r, 4'b0011, 4'b1111, 4'b0001, 4'b0001, pk(0,0,0,0), 8'h03);
      step("t6c4", 4'b0010, r, 4'b0010, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);
      step("t6c5", 4'b0010, r, 4'b0010, 4'b1111, 4'b0010, 4'b0001, pk(1,0,0,0), 8'h03);
      step("t6c6", 4'b0000, r, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 8'h00);

      check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
